fg_dac_write_ctrl: RTL and testbench

Downstream stage of the function generator. It consumes each output sample and its one-cycle valid strobe, and turns them into a timed parallel-DAC write cycle: data setup, an active-low WR pulse, data hold, then a programmable settling interval. It replaces the ad-hoc strobe-stretching at top level. It adds a one-deep pending buffer (latest sample wins), a sticky overrun flag, and control of the DAC clear and power-down pins.

---
 rtl/fg_dac_pkg.sv | 26 ++
 rtl/fg_phase_counter.sv | 28 ++
 rtl/fg_dac_write_ctrl.sv | 159 +++++++++++++++
 tb/tb_fg_dac_write_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_dac_pkg.sv
// Shared FSM encoding and phase-counter sizing for the DAC write controller.
package fg_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_SETTLE
  } state_t;

  // Counter must hold the settle value and every fixed phase length minus one.
  function automatic int unsigned cnt_width(input int unsigned settle_w,
                                            input int unsigned setup,
                                            input int unsigned wr,
                                            input int unsigned hold);
    int unsigned m;
    int unsigned c;
    m = setup;
    if (wr > m) m = wr;
    if (hold > m) m = hold;
    c = (m > 1) ? $clog2(m) : 1;
    return (settle_w > c) ? settle_w : c;
  endfunction

endpackage

// File: rtl/fg_phase_counter.sv
// Load/down-count timer shared by all write-cycle phases; stops at zero.
module fg_phase_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrement saturates at zero so counts never wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_val_i;
    end else if (dec_i && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/fg_dac_write_ctrl.sv
// Turns generator sample strobes into timed parallel-DAC write cycles with a
// one-deep latest-wins pending buffer, overrun flag, clear and power-down.
module fg_dac_write_ctrl
  import fg_dac_pkg::*;
#(
  parameter int unsigned BITWIDTH        = 8,
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned WR_CYCLES       = 2,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned SETTLE_BITWIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [BITWIDTH-1:0]        sample_i,
  input  logic                       sampleValid_STRB_i,
  input  logic [SETTLE_BITWIDTH-1:0] settle_i,
  input  logic                       clear_i,
  input  logic                       overrunClear_i,
  output logic [BITWIDTH-1:0]        dac_data_o,
  output logic                       dac_wr_no,
  output logic                       dac_clr_no,
  output logic                       dac_pd_no,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int unsigned CNT_W = cnt_width(SETTLE_BITWIDTH, SETUP_CYCLES,
                                            WR_CYCLES, HOLD_CYCLES);

  state_t                     state;
  logic [BITWIDTH-1:0]        pend_data;
  logic                       pend_valid;
  logic [SETTLE_BITWIDTH-1:0] settle_q;

  logic                       start_c;
  logic                       accept_c;
  logic                       cnt_load_c;
  logic [CNT_W-1:0]           cnt_val_c;
  logic                       cnt_dec_c;
  logic                       cnt_zero_c;

  // Start/accept qualification and the counter reload for the next phase.
  always_comb begin
    start_c    = (state == ST_IDLE) && enable_i && !clear_i &&
                 (pend_valid || sampleValid_STRB_i);
    accept_c   = sampleValid_STRB_i && enable_i && !clear_i;
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;
    cnt_dec_c  = (state != ST_IDLE);
    if (!clear_i) begin
      case (state)
        ST_IDLE: if (start_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(SETUP_CYCLES - 1);
        end
        ST_SETUP: if (cnt_zero_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(WR_CYCLES - 1);
        end
        ST_WRITE: if (cnt_zero_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(HOLD_CYCLES - 1);
        end
        ST_HOLD: if (cnt_zero_c && (settle_q != '0)) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(settle_q) - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  fg_phase_counter #(.WIDTH(CNT_W)) u_phase_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .dec_i      (cnt_dec_c),
    .zero_c     (cnt_zero_c)
  );

  // Write-cycle FSM, pending buffer and all registered DAC/status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      settle_q   <= '0;
      dac_data_o <= '0;
      dac_wr_no  <= 1'b1;
      dac_clr_no <= 1'b0;
      dac_pd_no  <= 1'b1;
      busy_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      dac_clr_no <= ~clear_i;
      dac_pd_no  <= enable_i | (state != ST_IDLE);
      if (overrunClear_i) overrun_o <= 1'b0;

      if (clear_i) begin
        state      <= ST_IDLE;
        dac_wr_no  <= 1'b1;
        dac_data_o <= '0;
        pend_valid <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_c) begin
              dac_data_o <= pend_valid ? pend_data : sample_i;
              settle_q   <= settle_i;
              busy_o     <= 1'b1;
              state      <= ST_SETUP;
              // A strobe arriving while pending drains refills the slot.
              pend_valid <= pend_valid && sampleValid_STRB_i;
              pend_data  <= sample_i;
            end else begin
              pend_valid <= 1'b0;
            end
          end
          ST_SETUP: if (cnt_zero_c) begin
            state     <= ST_WRITE;
            dac_wr_no <= 1'b0;
          end
          ST_WRITE: if (cnt_zero_c) begin
            state     <= ST_HOLD;
            dac_wr_no <= 1'b1;
          end
          ST_HOLD: if (cnt_zero_c) begin
            if (settle_q != '0) begin
              state <= ST_SETTLE;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
          ST_SETTLE: if (cnt_zero_c) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase

        // Strobes during a write land in pending; overwriting a full slot flags overrun.
        if (state != ST_IDLE) begin
          if (!enable_i) begin
            pend_valid <= 1'b0;
          end else if (accept_c) begin
            pend_data  <= sample_i;
            pend_valid <= 1'b1;
            if (pend_valid) overrun_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fg_dac_write_ctrl.sv
// Randomised and directed bench for fg_dac_write_ctrl against a timeline model.
module tb_fg_dac_write_ctrl;

  localparam int BW  = 8;
  localparam int SU  = 1;
  localparam int WRC = 2;
  localparam int HO  = 1;
  localparam int SW  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [BW-1:0] sample;
  logic          strb;
  logic [SW-1:0] settle;
  logic          clear;
  logic          ovc;
  logic [BW-1:0] dac_data_o;
  logic          dac_wr_no, dac_clr_no, dac_pd_no, busy_o, overrun_o;

  always #5 clk = ~clk;

  fg_dac_write_ctrl #(
    .BITWIDTH(BW), .SETUP_CYCLES(SU), .WR_CYCLES(WRC),
    .HOLD_CYCLES(HO), .SETTLE_BITWIDTH(SW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .sample_i           (sample),
    .sampleValid_STRB_i (strb),
    .settle_i           (settle),
    .clear_i            (clear),
    .overrunClear_i     (ovc),
    .dac_data_o         (dac_data_o),
    .dac_wr_no          (dac_wr_no),
    .dac_clr_no         (dac_clr_no),
    .dac_pd_no          (dac_pd_no),
    .busy_o             (busy_o),
    .overrun_o          (overrun_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a write loaded at edge m_start occupies m_len cycles after it.
  int            now_e = 0;
  bit            m_active = 1'b0;
  int            m_start = 0;
  int            m_len = 0;
  bit            m_pend = 1'b0;
  logic [BW-1:0] m_pdata = '0;
  logic [BW-1:0] m_data = '0;
  bit            m_ovr = 1'b0;
  bit            m_clr = 1'b0;
  bit            m_pd = 1'b1;

  localparam logic [BW+4:0] RESET_VEC = {8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [BW+4:0] obs();
    return {dac_data_o, dac_wr_no, dac_clr_no, dac_pd_no, busy_o, overrun_o};
  endfunction

  function automatic logic [BW+4:0] expected();
    int   p;
    logic bsy, wr_low;
    p      = now_e - m_start;
    bsy    = m_active && (p < m_len);
    wr_low = m_active && (p >= SU) && (p < SU + WRC);
    return {m_data, ~wr_low, m_clr, m_pd, bsy, m_ovr};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_pend = 1'b0; m_data = '0; m_ovr = 1'b0;
    m_clr = 1'b0; m_pd = 1'b1;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic step();
    bit idle;
    bit set;
    idle = !(m_active && ((now_e - m_start) < m_len));
    set  = 1'b0;
    if (clear) begin
      m_active = 1'b0; m_pend = 1'b0; m_data = '0;
      if (ovc) m_ovr = 1'b0;
    end else begin
      if (idle) begin
        if (enable && (m_pend || strb)) begin
          m_data   = m_pend ? m_pdata : sample;
          m_start  = now_e + 1;
          m_len    = SU + WRC + HO + int'(settle);
          m_active = 1'b1;
          if (m_pend && strb) m_pdata = sample;
          else m_pend = 1'b0;
        end else begin
          m_pend = 1'b0;
        end
      end else if (!enable) begin
        m_pend = 1'b0;
      end else if (strb) begin
        if (m_pend) set = 1'b1;
        m_pend  = 1'b1;
        m_pdata = sample;
      end
      if (set) m_ovr = 1'b1;
      else if (ovc) m_ovr = 1'b0;
    end
    m_pd  = enable || !idle;
    m_clr = !clear;
    now_e++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sample = '0; strb = 1'b0; settle = '0;
    clear = 1'b0; ovc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_values got=%h exp=%h", obs(), RESET_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
    end
  endtask

  task automatic test_single_write();
    int busy_cnt, wr_cnt, first_wr;
    busy_cnt = 0; wr_cnt = 0; first_wr = -1;
    strb = 1'b1; sample = 8'hA5; settle = 10'd3;
    for (int i = 0; i < 12; i++) begin
      step();
      strb = 1'b0;
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL single cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (busy_o) busy_cnt++;
      if (!dac_wr_no) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = i;
      end
    end
    vectors++;
    if (busy_cnt != SU + WRC + HO + 3 || wr_cnt != WRC || first_wr != SU || dac_data_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_timing busy=%0d wr=%0d first_wr=%0d data=%h exp busy=7 wr=2 first_wr=1 data=a5",
               busy_cnt, wr_cnt, first_wr, dac_data_o);
    end
  endtask

  task automatic test_overrun();
    logic [BW-1:0] written[$];
    logic          prev_wr;
    prev_wr = 1'b1;
    settle = 10'd5;
    for (int r = 0; r < 26; r++) begin
      strb   = (r == 0) || (r == 2) || (r == 4);
      sample = (r == 0) ? 8'h11 : (r == 2) ? 8'h22 : 8'h33;
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL overrun_seq cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (r == 4) begin
        vectors++;
        if (overrun_o !== 1'b1) begin
          miscompares++;
          $display("FAIL overrun_set got=%b exp=1", overrun_o);
        end
      end
      if (prev_wr && !dac_wr_no) written.push_back(dac_data_o);
      prev_wr = dac_wr_no;
    end
    strb = 1'b0;
    vectors++;
    if (written.size() != 2 || written[0] !== 8'h11 || written[1] !== 8'h33) begin
      miscompares++;
      $display("FAIL overrun_writes count=%0d exp 2 writes 11,33", written.size());
    end
    ovc = 1'b1;
    step();
    ovc = 1'b0;
    step();
    vectors++;
    if (overrun_o !== 1'b0 || obs() !== expected()) begin
      miscompares++;
      $display("FAIL overrun_clear got=%h exp=%h", obs(), expected());
    end
  endtask

  task automatic test_clear();
    bit found;
    found = 1'b0;
    settle = 10'd2; strb = 1'b1; sample = 8'h5A;
    step();
    strb = 1'b0;
    step();
    strb = 1'b1; sample = 8'h66;
    for (int i = 0; i < 10; i++) begin
      step();
      strb = 1'b0;
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL clear_pre cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (!dac_wr_no) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL clear_wait_wr got=timeout exp=wr_low");
    end
    clear = 1'b1; strb = 1'b1; sample = 8'h99;
    step();
    clear = 1'b0; strb = 1'b0;
    vectors++;
    if (dac_wr_no !== 1'b1 || dac_data_o !== 8'h00 || busy_o !== 1'b0 || dac_clr_no !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_effect got=%h exp wr=1 data=00 busy=0 clr=0", obs());
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (obs() !== expected() || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_post cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
    end
  endtask

  task automatic test_enable();
    int   falls;
    logic prev_wr;
    bit   saw7f;
    falls = 0; prev_wr = 1'b1; saw7f = 1'b0;
    settle = 10'd4;
    for (int r = 0; r < 20; r++) begin
      strb   = (r == 0) || (r == 2);
      sample = (r == 0) ? 8'h3C : 8'h4D;
      if (r == 5) enable = 1'b0;
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (prev_wr && !dac_wr_no) falls++;
      prev_wr = dac_wr_no;
    end
    strb = 1'b0;
    vectors++;
    if (falls != 1 || dac_pd_no !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_discard writes=%0d pd=%b exp writes=1 pd=0", falls, dac_pd_no);
    end
    enable = 1'b1; strb = 1'b1; sample = 8'h7F;
    for (int i = 0; i < 12; i++) begin
      step();
      strb = 1'b0;
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL enable_return cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (!dac_wr_no && dac_data_o === 8'h7F) saw7f = 1'b1;
    end
    vectors++;
    if (!saw7f || dac_pd_no !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_rewrite saw7f=%b pd=%b exp 1 1", saw7f, dac_pd_no);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] sent[$];
    logic [BW-1:0] written[$];
    logic          prev_wr, prev_busy, any_ovr;
    int            idle_run, bad_gaps;
    bit            seen_busy;
    prev_wr = 1'b1; prev_busy = 1'b0; any_ovr = 1'b0;
    idle_run = 0; bad_gaps = 0; seen_busy = 1'b0;
    ovc = 1'b1; settle = '0;
    step();
    ovc = 1'b0;
    for (int r = 0; r < 30; r++) begin
      strb   = (r % 4 == 0) && (r <= 12);
      sample = BW'($urandom);
      if (strb) sent.push_back(sample);
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
      if (overrun_o) any_ovr = 1'b1;
      if (prev_wr && !dac_wr_no) written.push_back(dac_data_o);
      prev_wr = dac_wr_no;
      if (busy_o && !prev_busy && seen_busy && idle_run != 1) bad_gaps++;
      if (busy_o) begin seen_busy = 1'b1; idle_run = 0; end
      else idle_run++;
      prev_busy = busy_o;
    end
    strb = 1'b0;
    vectors++;
    if (written != sent || any_ovr || bad_gaps != 0) begin
      miscompares++;
      $display("FAIL b2b_summary writes=%0d/%0d ovr=%b bad_gaps=%0d exp 4/4 0 0",
               written.size(), sent.size(), any_ovr, bad_gaps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      enable = ($urandom % 16) != 0;
      strb   = ($urandom % 3) == 0;
      sample = BW'($urandom);
      settle = SW'($urandom % 6);
      clear  = ($urandom % 40) == 0;
      ovc    = ($urandom % 20) == 0;
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
    end
    enable = 1'b1; strb = 1'b0; clear = 1'b0; ovc = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    settle = 10'd2; strb = 1'b1; sample = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      step();
      strb = 1'b0;
      if (!dac_wr_no) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL areset_wait_wr got=timeout exp=wr_low");
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== RESET_VEC) begin
      miscompares++;
      $display("FAIL areset_immediate got=%h exp=%h", obs(), RESET_VEC);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (obs() !== expected()) begin
        miscompares++;
        $display("FAIL areset_release cyc=%0d got=%h exp=%h", now_e, obs(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overrun();
    test_clear();
    test_enable();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
